// File: rtl/clock_divider_prog.sv
// ============================================================================
// Module   : clock_divider_prog
// Purpose  : Runtime-programmable clock divider producing a near-50% divided
//            clock and a one-cycle tick per period. Optional macro
//            CLKDIV_PEND_EN exposes the pending-divisor flag as div_pend.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_divider_prog #(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10000
) (
    input  logic             clk_in,
    input  logic             res,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick
`ifdef CLKDIV_PEND_EN
    ,
    output logic             div_pend
`endif
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] act;
    logic [WIDTH-1:0] shd;
    logic             pnd;

    logic [WIDTH-1:0] div_clamped;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] act_next;
    logic [WIDTH-1:0] shd_next;
    logic             pnd_next;
    logic             clk_next;
    logic             tick_next;
    logic             wrap;

    always_comb begin
        div_clamped = (div_in < MIN_DIV) ? MIN_DIV : div_in;
        wrap        = en && (cnt >= (act - 1'b1));

        cnt_next  = cnt;
        act_next  = act;
        shd_next  = shd;
        pnd_next  = pnd;
        clk_next  = clk_out;
        tick_next = 1'b0;

        if (div_load) begin
            shd_next = div_clamped;
        end

        if (wrap) begin
            cnt_next  = '0;
            tick_next = 1'b1;
            pnd_next  = 1'b0;
            // A load coinciding with the wrap bypasses the shadow entirely.
            if (div_load) begin
                act_next = div_clamped;
            end else if (pnd) begin
                act_next = shd;
            end
        end else begin
            if (en) begin
                cnt_next = cnt + 1'b1;
            end
            if (div_load) begin
                pnd_next = 1'b1;
            end
        end

        // Low for floor(N/2) cycles, high for the remaining ceil(N/2).
        if (en) begin
            clk_next = (cnt_next >= (act_next >> 1));
        end
    end

    always_ff @(posedge clk_in or posedge res) begin
        if (res) begin
            cnt     <= '0;
            act     <= RESET_DIV;
            shd     <= RESET_DIV;
            pnd     <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            act     <= act_next;
            shd     <= shd_next;
            pnd     <= pnd_next;
            clk_out <= clk_next;
            tick    <= tick_next;
        end
    end

`ifdef CLKDIV_PEND_EN
    assign div_pend = pnd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_prog.sv
// ============================================================================
// Module   : tb_clock_divider_prog
// Purpose  : Self-checking bench for clock_divider_prog (DEFAULT_DIV = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_divider_prog;

    localparam int W   = 16;
    localparam int DEF = 4;

    logic         clk_in = 1'b0;
    logic         res;
    logic         en;
    logic [W-1:0] div_in;
    logic         div_load;
    logic         clk_out;
    logic         tick;
`ifdef CLKDIV_PEND_EN
    logic         div_pend;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the current period and its length.
    int m_ph, m_per, m_shd;
    bit m_pnd, m_clk, m_tick;

    clock_divider_prog #(.WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk_in   (clk_in),
        .res      (res),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .clk_out  (clk_out),
        .tick     (tick)
`ifdef CLKDIV_PEND_EN
        ,
        .div_pend (div_pend)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic model_reset();
        m_ph = 0; m_per = DEF; m_shd = DEF; m_pnd = 0; m_clk = 0; m_tick = 0;
    endtask

    // Advance one clock, update the model from the inputs seen at the edge.
    task automatic step();
        int d;
        @(posedge clk_in);
        if (res) begin
            model_reset();
        end else begin
            d = (int'(div_in) < 2) ? 2 : int'(div_in);
            if (en) begin
                if (m_ph == m_per - 1) begin
                    m_ph = 0; m_tick = 1;
                    if (div_load) m_per = d;
                    else if (m_pnd) m_per = m_shd;
                    m_pnd = 0;
                end else begin
                    m_ph++; m_tick = 0;
                    if (div_load) begin m_shd = d; m_pnd = 1; end
                end
                m_clk = (m_ph >= m_per / 2);
            end else begin
                m_tick = 0;
                if (div_load) begin m_shd = d; m_pnd = 1; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        res = 1'b1; en = 1'b0; div_load = 1'b0; div_in = '0;
        #3;
        model_reset();
        checks++;
        if (clk_out !== 1'b0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs clk_out=%b tick=%b expected 0 0", clk_out, tick);
        end
`ifdef CLKDIV_PEND_EN
        checks++;
        if (div_pend !== 1'b0) begin
            failures++;
            $display("FAIL reset_pend div_pend=%b expected 0", div_pend);
        end
`endif
        step(); step();
        res = 1'b0;
    endtask

    task automatic test_default_period();
        bit ec, et;
        en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            step();
            ec = ((k % 4) >= 2);
            et = ((k % 4) == 0);
            checks++;
            if (clk_out !== ec || tick !== et) begin
                failures++;
                $display("FAIL default_period cyc=%0d clk_out=%b tick=%b expected %b %b",
                         k, clk_out, tick, ec, et);
            end
        end
    endtask

    task automatic test_runtime_load();
        int n;
        bit found;
        for (int i = 0; i < 10 && m_ph != 1; i++) step();
        div_in = 16'd6; div_load = 1'b1;
        step();
        div_load = 1'b0;
        checks++;
        if (clk_out !== m_clk || tick !== m_tick) begin
            failures++;
            $display("FAIL load_model clk_out=%b tick=%b expected %b %b", clk_out, tick, m_clk, m_tick);
        end
`ifdef CLKDIV_PEND_EN
        checks++;
        if (div_pend !== 1'b1) begin
            failures++;
            $display("FAIL load_pend_set div_pend=%b expected 1", div_pend);
        end
`endif
        // The old period of 4 must still finish: two more cycles to the wrap.
        n = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(); n++;
            if (tick === 1'b1) found = 1;
        end
        checks++;
        if (!found || n != 2) begin
            failures++;
            $display("FAIL load_old_period_end cycles=%0d found=%b expected 2 1", n, found);
        end
`ifdef CLKDIV_PEND_EN
        checks++;
        if (div_pend !== 1'b0) begin
            failures++;
            $display("FAIL load_pend_clear div_pend=%b expected 0", div_pend);
        end
`endif
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (clk_out !== (i >= 3) || tick !== (i == 0)) begin
                failures++;
                $display("FAIL load_new_period idx=%0d clk_out=%b tick=%b expected %b %b",
                         i, clk_out, tick, (i >= 3), (i == 0));
            end
            step();
        end
        checks++;
        if (tick !== 1'b1) begin
            failures++;
            $display("FAIL load_period_len tick=%b expected 1 after 6 cycles", tick);
        end
    endtask

    task automatic test_clamp_odd();
        bit found;
        // Currently at cnt=0 of a 6-cycle period: a non-wrap load.
        div_in = 16'd0; div_load = 1'b1;
        step();
        div_load = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (tick === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL clamp_wrap_timeout tick=%b expected 1", tick);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (clk_out !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL clamp_period2 idx=%0d clk_out=%b expected %b", i, clk_out, (i % 2 == 1));
            end
            step();
        end
        div_in = 16'd5; div_load = 1'b1;
        step();
        div_load = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (tick === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL odd_wrap_timeout tick=%b expected 1", tick);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (clk_out !== ((i % 5) >= 2) || tick !== ((i % 5) == 0)) begin
                failures++;
                $display("FAIL odd_period5 idx=%0d clk_out=%b tick=%b expected %b %b",
                         i, clk_out, tick, ((i % 5) >= 2), ((i % 5) == 0));
            end
            step();
        end
    endtask

    task automatic measure_gap(output int n);
        bit found;
        n = 0; found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(); n++;
            if (tick === 1'b1) found = 1;
        end
        if (!found) n = -1;
    endtask

    task automatic test_edge_loads();
        int n;
        for (int i = 0; i < 10 && m_ph != m_per - 1; i++) step();
        div_in = 16'd8; div_load = 1'b1;
        step();
        div_load = 1'b0;
        checks++;
        if (tick !== 1'b1 || clk_out !== m_clk) begin
            failures++;
            $display("FAIL wrap_load tick=%b clk_out=%b expected 1 %b", tick, clk_out, m_clk);
        end
`ifdef CLKDIV_PEND_EN
        checks++;
        if (div_pend !== 1'b0) begin
            failures++;
            $display("FAIL wrap_load_pend div_pend=%b expected 0", div_pend);
        end
`endif
        measure_gap(n);
        checks++;
        if (n != 8) begin
            failures++;
            $display("FAIL wrap_load_period got=%0d expected 8", n);
        end
        step();
        div_in = 16'd7; div_load = 1'b1;
        step();
        div_in = 16'd9;
        step();
        div_load = 1'b0;
        measure_gap(n);
        measure_gap(n);
        checks++;
        if (n != 9) begin
            failures++;
            $display("FAIL last_load_wins got=%0d expected 9", n);
        end
    endtask

    task automatic test_enable_hold();
        int n;
        bit held;
        held = 0;
        step(); step();
        en = 1'b0;
        held = clk_out;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (clk_out !== held || tick !== 1'b0) begin
                failures++;
                $display("FAIL enable_hold idx=%0d clk_out=%b tick=%b expected %b 0", i, clk_out, tick, held);
            end
        end
        en = 1'b1;
        measure_gap(n);
        checks++;
        if (n != 9 - 2) begin
            failures++;
            $display("FAIL enable_resume got=%0d expected 7", n);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        step();
        div_in = 16'd3; div_load = 1'b1;
        step();
        div_load = 1'b0;
        step(); step(); step();
        #2;
        res = 1'b1;
        #1;
        model_reset();
        checks++;
        if (clk_out !== 1'b0 || tick !== 1'b0) begin
            failures++;
            $display("FAIL async_reset clk_out=%b tick=%b expected 0 0", clk_out, tick);
        end
`ifdef CLKDIV_PEND_EN
        checks++;
        if (div_pend !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_pend div_pend=%b expected 0", div_pend);
        end
`endif
        step();
        res = 1'b0;
        measure_gap(n);
        checks++;
        if (n != DEF) begin
            failures++;
            $display("FAIL reset_first_period got=%0d expected %0d", n, DEF);
        end
        measure_gap(n);
        checks++;
        if (n != DEF) begin
            failures++;
            $display("FAIL reset_pending_discarded got=%0d expected %0d", n, DEF);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            div_load = ($urandom_range(0, 11) == 0);
            div_in   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3))
                                                   : W'($urandom_range(2, 12));
            step();
            checks++;
            if (clk_out !== m_clk || tick !== m_tick) begin
                failures++;
                $display("FAIL random cyc=%0d clk_out=%b tick=%b expected %b %b",
                         i, clk_out, tick, m_clk, m_tick);
            end
`ifdef CLKDIV_PEND_EN
            checks++;
            if (div_pend !== m_pnd) begin
                failures++;
                $display("FAIL random_pend cyc=%0d div_pend=%b expected %b", i, div_pend, m_pnd);
            end
`endif
        end
        div_load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_runtime_load();
        test_clamp_odd();
        test_edge_loads();
        test_enable_hold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
